// File: rtl/mem_bus_bridge_if.sv
// Core-side and memory-side signal bundle of the memory bus bridge.
// The slave modport is the bridge view; the master modport is the core/memory environment view.
interface mem_bus_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    // core side
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_read_en;
    logic              core_write_en;
    logic [1:0]        core_width;
    logic [31:0]       core_rdata;
    logic              core_busy;
    logic              bus_err;
    logic              misalign_err;
    // memory side
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-3:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;
    logic              m_ack;
    logic [31:0]       m_rdata;

    modport slave (
        input  core_addr, core_wdata, core_read_en, core_write_en, core_width,
        output core_rdata, core_busy, bus_err, misalign_err,
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_ack, m_rdata
    );

    modport master (
        output core_addr, core_wdata, core_read_en, core_write_en, core_width,
        input  core_rdata, core_busy, bus_err, misalign_err,
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Core bus to word-addressed req/ack bridge: lane replication/extraction, ack timeout, misalign trap under MISALIGN_TRAP_EN.
// Latency >= 3 cycles (accept, REQ until ack, DONE); core_busy stalls the core from accept through REQ.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input logic             clk,
    input logic             reset,
    mem_bus_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        width_q, width_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-3:0] m_addr_q, m_addr_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [1:0]        w_norm;
    logic              busy;
`ifdef MISALIGN_TRAP_EN
    logic              misalign_err_q, misalign_err_d;
    logic              misaligned;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            we_q           <= 1'b0;
            width_q        <= 2'd0;
            off_q          <= 2'd0;
            m_addr_q       <= '0;
            m_be_q         <= 4'd0;
            m_wdata_q      <= 32'd0;
            rdata_q        <= 32'd0;
            bus_err_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            width_q        <= width_d;
            off_q          <= off_d;
            m_addr_q       <= m_addr_d;
            m_be_q         <= m_be_d;
            m_wdata_q      <= m_wdata_d;
            rdata_q        <= rdata_d;
            bus_err_q      <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    // Reserved width code behaves exactly like a word access.
    assign w_norm = (bus.core_width == 2'd3) ? 2'd2 : bus.core_width;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((w_norm == 2'd1) && bus.core_addr[0]) ||
                        ((w_norm == 2'd2) && (bus.core_addr[1:0] != 2'd0));
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        width_d        = width_q;
        off_d          = off_q;
        m_addr_d       = m_addr_q;
        m_be_d         = m_be_q;
        m_wdata_d      = m_wdata_q;
        rdata_d        = rdata_q;
        bus_err_d      = 1'b0;
        busy           = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.core_write_en || bus.core_read_en) begin
                    busy     = 1'b1;
                    we_d     = bus.core_write_en;
                    width_d  = w_norm;
                    cnt_d    = '0;
                    m_addr_d = bus.core_addr[ADDR_W-1:2];
                    // Low address bits that cannot be honoured for the width are dropped here.
                    case (w_norm)
                        2'd0: begin
                            off_d     = bus.core_addr[1:0];
                            m_be_d    = 4'b0001 << bus.core_addr[1:0];
                            m_wdata_d = {4{bus.core_wdata[7:0]}};
                        end
                        2'd1: begin
                            off_d     = {bus.core_addr[1], 1'b0};
                            m_be_d    = bus.core_addr[1] ? 4'b1100 : 4'b0011;
                            m_wdata_d = {2{bus.core_wdata[15:0]}};
                        end
                        default: begin
                            off_d     = 2'd0;
                            m_be_d    = 4'b1111;
                            m_wdata_d = bus.core_wdata;
                        end
                    endcase
                    state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d        = S_DONE;
                        misalign_err_d = 1'b1;
                        rdata_d        = 32'hFFFF_FFFF;
                    end
`endif
                end
            end
            S_REQ: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.m_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        case (width_q)
                            2'd0:    rdata_d = {24'd0, bus.m_rdata[{off_q, 3'b000} +: 8]};
                            2'd1:    rdata_d = off_q[1] ? {16'd0, bus.m_rdata[31:16]}
                                                        : {16'd0, bus.m_rdata[15:0]};
                            default: rdata_d = bus.m_rdata;
                        endcase
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'hFFFF_FFFF;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.m_req        = (state_q == S_REQ);
    assign bus.m_we         = we_q;
    assign bus.m_addr       = m_addr_q;
    assign bus.m_be         = m_be_q;
    assign bus.m_wdata      = m_wdata_q;
    assign bus.core_rdata   = rdata_q;
    assign bus.core_busy    = busy;
    assign bus.bus_err      = bus_err_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.misalign_err = misalign_err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge against a byte-lane reference model (TIMEOUT=4).
module tb_mem_bus_bridge;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] model_rd = 32'd0;
    logic [31:0] last_addr, last_be, last_wdata, last_rd;
    logic        last_we, last_berr, last_merr;
    int          last_busy, last_req;

    mem_bus_bridge_if #(.ADDR_W(32)) bus ();

    mem_bus_bridge #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access; ack_dly = REQ cycle index carrying m_ack (>= TO means never).
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                             input logic rd_too, input logic [1:0] width, input int ack_dly,
                             input logic [31:0] mem_rd);
        int          size, lo, off, exp_req, req_seen, busy_cnt;
        bit          mis, trap, exp_berr, exp_merr, done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;

        size = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        lo   = int'(addr & 32'd3);
        mis  = (lo % size) != 0;
        off  = (lo / size) * size;
        exp_be = 4'd0;
        for (int i = 0; i < size; i++) exp_be[off + i] = 1'b1;
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % size) +: 8];
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        exp_berr = 1'b0;
        exp_merr = 1'b0;
        if (trap) begin
            exp_req  = 0;
            exp_merr = 1'b1;
            exp_rd   = 32'hFFFF_FFFF;
        end else if (ack_dly < TO) begin
            exp_req = ack_dly + 1;
            if (wr) exp_rd = model_rd;
            else begin
                exp_rd = 32'd0;
                for (int i = 0; i < size; i++) exp_rd[8*i +: 8] = mem_rd[8*(off + i) +: 8];
            end
        end else begin
            exp_req  = TO;
            exp_berr = 1'b1;
            exp_rd   = 32'hFFFF_FFFF;
        end

        @(negedge clk);
        bus.core_addr     = addr;
        bus.core_wdata    = wd;
        bus.core_width    = width;
        bus.core_write_en = wr;
        bus.core_read_en  = wr ? rd_too : 1'b1;
        #1;
        check_eq("busy_accept", {31'd0, bus.core_busy}, 32'd1);
        busy_cnt = 1;
        req_seen = 0;
        done     = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.m_req) begin
                busy_cnt += int'(bus.core_busy);
                check_eq("m_addr", {2'd0, bus.m_addr}, {2'd0, addr[31:2]});
                check_eq("m_be", {28'd0, bus.m_be}, {28'd0, exp_be});
                check_eq("m_we", {31'd0, bus.m_we}, {31'd0, wr});
                if (wr) check_eq("m_wdata", bus.m_wdata, exp_wd);
                last_addr  = {2'd0, bus.m_addr};
                last_be    = {28'd0, bus.m_be};
                last_wdata = bus.m_wdata;
                last_we    = bus.m_we;
                bus.m_ack   = (req_seen == ack_dly);
                bus.m_rdata = (req_seen == ack_dly) ? mem_rd : $urandom;
                req_seen++;
            end else begin
                done = 1'b1;
            end
        end
        check_eq("done_reached", {31'd0, done}, 32'd1);
        check_eq("req_cycles", req_seen, exp_req);
        check_eq("busy_done", {31'd0, bus.core_busy}, 32'd0);
        check_eq("rdata_done", bus.core_rdata, exp_rd);
        check_eq("bus_err", {31'd0, bus.bus_err}, {31'd0, exp_berr});
        check_eq("misalign_err", {31'd0, bus.misalign_err}, {31'd0, exp_merr});
        last_rd   = bus.core_rdata;
        last_berr = bus.bus_err;
        last_merr = bus.misalign_err;
        last_req  = req_seen;
        last_busy = busy_cnt;
        model_rd  = exp_rd;
        // release the request; a stray ack here must be ignored
        bus.core_write_en = 1'b0;
        bus.core_read_en  = 1'b0;
        bus.m_ack         = 1'($urandom_range(0, 1));
        bus.m_rdata       = $urandom;
        @(negedge clk);
        bus.m_ack = 1'b0;
        check_eq("rdata_hold", bus.core_rdata, exp_rd);
        check_eq("err_cleared", {30'd0, bus.bus_err, bus.misalign_err}, 32'd0);
        check_eq("idle_req", {31'd0, bus.m_req}, 32'd0);
    endtask

    initial begin
        reset             = 1'b0;
        bus.core_addr     = '0;
        bus.core_wdata    = '0;
        bus.core_read_en  = 1'b0;
        bus.core_write_en = 1'b0;
        bus.core_width    = 2'd0;
        bus.m_ack         = 1'b0;
        bus.m_rdata       = '0;
        #12;
        check_eq("rst_m_req", {31'd0, bus.m_req}, 32'd0);
        check_eq("rst_m_we", {31'd0, bus.m_we}, 32'd0);
        check_eq("rst_m_addr", {2'd0, bus.m_addr}, 32'd0);
        check_eq("rst_m_be", {28'd0, bus.m_be}, 32'd0);
        check_eq("rst_m_wdata", bus.m_wdata, 32'd0);
        check_eq("rst_rdata", bus.core_rdata, 32'd0);
        check_eq("rst_errs", {30'd0, bus.bus_err, bus.misalign_err}, 32'd0);
        #11 reset = 1'b1;

        do_access(32'h10, 32'd0, 1'b0, 1'b0, 2'd2, 2, 32'hDEADBEEF);
        check_eq("t1_m_addr", last_addr, 32'h4);
        check_eq("t1_m_be", last_be, 32'hF);
        check_eq("t1_busy_cycles", last_busy, 4);
        check_eq("t1_rdata", last_rd, 32'hDEADBEEF);

        do_access(32'h103, 32'h0000_00A5, 1'b1, 1'b0, 2'd0, 0, 32'h1234_5678);
        check_eq("t2_m_we", {31'd0, last_we}, 32'd1);
        check_eq("t2_m_addr", last_addr, 32'h40);
        check_eq("t2_m_be", last_be, 32'h8);
        check_eq("t2_m_wdata", last_wdata, 32'hA5A5A5A5);
        check_eq("t2_req_cycles", last_req, 1);

        do_access(32'h2, 32'd0, 1'b0, 1'b0, 2'd1, 1, 32'hBEEF1234);
        check_eq("t3_m_be", last_be, 32'hC);
        check_eq("t3_rdata_hi", last_rd, 32'h0000BEEF);
        do_access(32'h0, 32'd0, 1'b0, 1'b0, 2'd1, 0, 32'hBEEF1234);
        check_eq("t3_rdata_lo", last_rd, 32'h00001234);

        do_access(32'h20, 32'd0, 1'b0, 1'b0, 2'd2, 1000, 32'h0);
        check_eq("t4_req_cycles", last_req, 4);
        check_eq("t4_bus_err", {31'd0, last_berr}, 32'd1);
        check_eq("t4_rdata", last_rd, 32'hFFFFFFFF);

        do_access(32'h6, 32'd0, 1'b0, 1'b0, 2'd2, 0, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
        check_eq("t5_req_cycles", last_req, 0);
        check_eq("t5_misalign", {31'd0, last_merr}, 32'd1);
        check_eq("t5_rdata", last_rd, 32'hFFFFFFFF);
`else
        check_eq("t5_m_addr", last_addr, 32'h1);
        check_eq("t5_m_be", last_be, 32'hF);
        check_eq("t5_rdata", last_rd, 32'hCAFEF00D);
`endif

        // reset asserted between edges while in REQ
        do_access(32'h44, 32'd0, 1'b0, 1'b0, 2'd2, 0, 32'h5A5A_0F0F);
        @(negedge clk);
        bus.core_addr    = 32'h80;
        bus.core_width   = 2'd2;
        bus.core_read_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_in_req", {31'd0, bus.m_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_rst_m_req", {31'd0, bus.m_req}, 32'd0);
        check_eq("t6_rst_rdata", bus.core_rdata, 32'd0);
        bus.core_read_en = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        model_rd = 32'd0;
        @(negedge clk);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.m_ack = 1'b0;
        check_eq("t6_late_ack_req", {31'd0, bus.m_req}, 32'd0);
        check_eq("t6_late_ack_rdata", bus.core_rdata, 32'd0);
        check_eq("t6_late_ack_busy", {31'd0, bus.core_busy}, 32'd0);
        check_eq("t6_late_ack_err", {31'd0, bus.bus_err}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            do_access($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
